rv32i_lsu_ctrl: RTL

Load/store sequencing controller for the memory stage of the pipelined RV32I core. Accepts one load or store per memory-stage slot (width encoded as `width_type_enum`), drives a request/grant/response data-memory port with byte enables and lane-shifted data, and sign/zero-extends load data. Holds `stall_o` high until the access completes, and detects misaligned accesses and memory timeouts.

---
 rtl/rv32i_lsu_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/rv32i_lsu_ctrl.sv
// Memory-stage load/store sequencer: request/grant/response data port with lane steering and load extension.
// Define RV32I_LSU_MISALIGN_TRAP_EN to fault misaligned half/word accesses instead of aligning them down.
module rv32i_lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid_i,
    input  logic        ex_load_i,
    input  logic        ex_store_i,
    input  logic [2:0]  ex_width_i,
    input  logic [31:0] ex_addr_i,
    input  logic [31:0] ex_wdata_i,
    output logic        stall_o,
    output logic        done_o,
    output logic        fault_o,
    output logic [31:0] rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        BYTE               = 3'd0,
        HALF_WORD          = 3'd1,
        WORD               = 3'd2,
        BYTE_UNSIGNED      = 3'd3,
        HALF_WORD_UNSIGNED = 3'd4
    } width_type_enum;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait
    } state_e;

    state_e         state_q;
    logic [CntW-1:0] cnt_q;
    logic           load_q;
    width_type_enum width_q;
    logic [29:0]    addr_q;
    logic [1:0]     off_q;
    logic [3:0]     be_q;
    logic [31:0]    wdata_q;

    logic        accept;
    logic        width_legal;
    logic        misaligned;
    logic        bad_req;
    logic [1:0]  off_eff;
    logic [3:0]  be_lane;
    logic [31:0] wdata_lane;

    // Request decode and lane steering for the instruction offered in the accept cycle.
    always_comb begin
        accept      = (state_q == StIdle) && ex_valid_i && (ex_load_i || ex_store_i);
        width_legal = (ex_width_i <= 3'd4);
        off_eff     = ex_addr_i[1:0];
        misaligned  = 1'b0;
        case (ex_width_i)
            HALF_WORD, HALF_WORD_UNSIGNED: misaligned = ex_addr_i[0];
            WORD:                          misaligned = (ex_addr_i[1:0] != 2'b00);
            default:                       misaligned = 1'b0;
        endcase
`ifdef RV32I_LSU_MISALIGN_TRAP_EN
        bad_req = !width_legal || misaligned;
`else
        bad_req = !width_legal;
        if (misaligned) begin
            if (ex_width_i == WORD) begin
                off_eff = 2'b00;
            end else begin
                off_eff = {ex_addr_i[1], 1'b0};
            end
        end
`endif
        be_lane    = 4'b1111;
        wdata_lane = ex_wdata_i;
        case (ex_width_i)
            BYTE, BYTE_UNSIGNED: begin
                be_lane    = 4'b0001 << off_eff;
                wdata_lane = {4{ex_wdata_i[7:0]}};
            end
            HALF_WORD, HALF_WORD_UNSIGNED: begin
                be_lane    = 4'b0011 << off_eff;
                wdata_lane = {2{ex_wdata_i[15:0]}};
            end
            default: begin
                be_lane    = 4'b1111;
                wdata_lane = ex_wdata_i;
            end
        endcase
    end

    logic [31:0] rdata_shift;
    logic [31:0] rdata_ext;
    logic        store_done;
    logic        load_done;
    logic        timeout;

    always_comb begin
        rdata_shift = mem_rdata_i >> {off_q, 3'b000};
        case (width_q)
            BYTE:               rdata_ext = {{24{rdata_shift[7]}}, rdata_shift[7:0]};
            HALF_WORD:          rdata_ext = {{16{rdata_shift[15]}}, rdata_shift[15:0]};
            BYTE_UNSIGNED:      rdata_ext = {24'd0, rdata_shift[7:0]};
            HALF_WORD_UNSIGNED: rdata_ext = {16'd0, rdata_shift[15:0]};
            default:            rdata_ext = rdata_shift;
        endcase

        store_done = (state_q == StReq) && !load_q && mem_gnt_i;
        load_done  = (state_q == StWait) && mem_rvalid_i;
        // A completion landing in the last budgeted cycle still counts as success.
        timeout    = (state_q != StIdle) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) &&
                     !store_done && !load_done;

        done_o  = (accept && bad_req) || store_done || load_done || timeout;
        fault_o = (accept && bad_req) || timeout;
        rdata_o = load_done ? rdata_ext : 32'd0;
        stall_o = ((state_q != StIdle) || accept) && !done_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            load_q  <= 1'b0;
            width_q <= BYTE;
            addr_q  <= '0;
            off_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        cnt_q <= '0;
                    end
                    if (accept && !bad_req) begin
                        state_q <= StReq;
                        load_q  <= ex_load_i;
                        width_q <= width_type_enum'(ex_width_i);
                        addr_q  <= ex_addr_i[31:2];
                        off_q   <= off_eff;
                        be_q    <= be_lane;
                        wdata_q <= wdata_lane;
                    end
                end
                StReq: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (timeout) begin
                        state_q <= StIdle;
                    end else if (mem_gnt_i) begin
                        state_q <= load_q ? StWait : StIdle;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (load_done || timeout) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Port fields come only from latched state so they hold steady while the request waits.
    assign mem_req_o   = (state_q == StReq);
    assign mem_we_o    = mem_req_o && !load_q;
    assign mem_be_o    = mem_req_o ? be_q : 4'b0000;
    assign mem_addr_o  = {addr_q, 2'b00};
    assign mem_wdata_o = wdata_q;

endmodule
